// File: rtl/tb_driver.sv
// Operand-pair generator (xorshift32 or manual source, bit-set/clear filters) behind a
// valid/ready output stage that counts accepted pairs; DRIVER_CTR_SAT_EN makes the counter saturate.
module tb_driver #(
  parameter int          WIDTH  = 32,
  parameter logic [31:0] SEED_A = 32'h00000001,
  parameter logic [31:0] SEED_B = 32'h00000002
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             freeze,
  input  logic             i_fselect,
  input  logic [WIDTH-1:0] i_fmanual_a,
  input  logic [WIDTH-1:0] i_fmanual_b,
  input  logic [WIDTH-1:0] i_fbitset_a,
  input  logic [WIDTH-1:0] i_fbitset_b,
  input  logic [WIDTH-1:0] i_fbitclr_a,
  input  logic [WIDTH-1:0] i_fbitclr_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  input  logic             i_ready,
  output logic [31:0]      o_data_ctr
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      prng_a_q, prng_a_d, prng_b_q, prng_b_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [31:0]      ctr_q, ctr_d;
  logic [31:0]      nxt_a, nxt_b;
  logic [WIDTH-1:0] raw_a, raw_b;
  logic             xfer, load;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  assign nxt_a = xs32(prng_a_q);
  assign nxt_b = xs32(prng_b_q);
  assign raw_a = i_fselect ? i_fmanual_a : nxt_a[WIDTH-1:0];
  assign raw_b = i_fselect ? i_fmanual_b : nxt_b[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    prng_a_d = prng_a_q;
    prng_b_d = prng_b_q;
    a_d      = a_q;
    b_d      = b_q;
    ctr_d    = ctr_q;
    load     = 1'b0;
    xfer     = (state_q == S_RUN) && i_ready;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Without a transfer the pending pair is held whatever enable does.
        if (xfer) begin
          if (enable) load = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      a_d = (raw_a | i_fbitset_a) & ~i_fbitclr_a;
      b_d = (raw_b | i_fbitset_b) & ~i_fbitclr_b;
      if (!i_fselect) begin
        prng_a_d = nxt_a;
        prng_b_d = nxt_b;
      end
    end

    if (xfer && !freeze) begin
`ifdef DRIVER_CTR_SAT_EN
      if (ctr_q != 32'hFFFFFFFF) ctr_d = ctr_q + 32'd1;
`else
      ctr_d = ctr_q + 32'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prng_a_q <= SEED_A;
      prng_b_q <= SEED_B;
      a_q      <= '0;
      b_q      <= '0;
      ctr_q    <= '0;
    end else begin
      state_q  <= state_d;
      prng_a_q <= prng_a_d;
      prng_b_q <= prng_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctr_q    <= ctr_d;
    end
  end

  assign o_valid    = (state_q == S_RUN);
  assign o_a        = a_q;
  assign o_b        = b_q;
  assign o_data_ctr = ctr_q;

endmodule
